// File: rtl/id_ex_stage_reg_pkg.sv
// Shared opcode constants, ID/EX bundle types and halt-drain FSM encoding for the ID/EX stage.
package id_ex_stage_reg_pkg;

    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcOpImm  = 7'b0010011;
    localparam logic [6:0] OpcSystem = 7'b1110011;

    localparam logic [31:0] EcallInst = {25'd0, OpcSystem};

    localparam int unsigned DefaultDrainCycles = 4;

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2
    } halt_state_e;

    typedef struct packed {
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic alu_src;
        logic write_enable;
        logic pc_to_reg;
        logic alu_op;
        logic is_ecall;
    } ex_ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
    } ex_data_t;

    function automatic logic [4:0] inst_rd(input logic [31:0] inst);
        return inst[11:7];
    endfunction

    function automatic logic [4:0] inst_rs1(input logic [31:0] inst);
        return inst[19:15];
    endfunction

    function automatic logic [4:0] inst_rs2(input logic [31:0] inst);
        return inst[24:20];
    endfunction

endpackage

// File: rtl/id_ex_stage_reg_halt_drain_fsm.sv
// Halt sequencer: after a halt ecall enters EX, bubbles the pipe for DrainCycles then halts.
module halt_drain_fsm
    import id_ex_stage_reg_pkg::*;
#(
    parameter int unsigned DrainCycles = DefaultDrainCycles
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic halt_capture_i,
    output logic run_o,
    output logic is_halted_o
);

    localparam int unsigned CntW = $clog2(DrainCycles) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DrainCycles - 1);

    halt_state_e     state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (halt_capture_i) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                // Counter stops at its terminal value, so it can never wrap.
                if (cnt_q == CntLast) begin
                    state_d = StHalted;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StRun;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign run_o       = (state_q == StRun);
    assign is_halted_o = (state_q == StHalted);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with flush/stall bubbles and a halt-ecall drain sequencer.
module id_ex_stage_reg
    import id_ex_stage_reg_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = DefaultDrainCycles
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_to_reg,
    input  logic        mem_write,
    input  logic        alu_src,
    input  logic        write_enable,
    input  logic        pc_to_reg,
    input  logic        alu_op,
    input  logic        is_ecall,
    input  logic        is_stall,
    input  logic        flush,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_inst,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic        id_x17_is_ten,
    output logic        ex_mem_read,
    output logic        ex_mem_to_reg,
    output logic        ex_mem_write,
    output logic        ex_alu_src,
    output logic        ex_write_enable,
    output logic        ex_pc_to_reg,
    output logic        ex_alu_op,
    output logic        ex_is_ecall,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_inst,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic        ex_valid,
    output logic        is_halted
);

    ex_ctrl_t ctrl_q, ctrl_d;
    ex_data_t data_q, data_d;
    logic     valid_q, valid_d;

    logic fsm_run;
    logic capture;
    logic halt_capture;

    // Outside RUN every cycle is a bubble; flush and stall both kill the ID instruction.
    assign capture      = fsm_run && !flush && !is_stall;
    assign halt_capture = capture && is_ecall && id_x17_is_ten;

    halt_drain_fsm #(
        .DrainCycles(DRAIN_CYCLES)
    ) u_halt_drain_fsm (
        .clk_i         (clk),
        .rst_ni        (reset),
        .halt_capture_i(halt_capture),
        .run_o         (fsm_run),
        .is_halted_o   (is_halted)
    );

    always_comb begin
        ctrl_d  = '0;
        data_d  = '0;
        valid_d = 1'b0;
        if (capture) begin
            ctrl_d.mem_read     = mem_read;
            ctrl_d.mem_to_reg   = mem_to_reg;
            ctrl_d.mem_write    = mem_write;
            ctrl_d.alu_src      = alu_src;
            ctrl_d.write_enable = write_enable;
            ctrl_d.pc_to_reg    = pc_to_reg;
            ctrl_d.alu_op       = alu_op;
            ctrl_d.is_ecall     = is_ecall;
            data_d.pc           = id_pc;
            data_d.inst         = id_inst;
            data_d.rs1_data     = id_rs1_data;
            data_d.rs2_data     = id_rs2_data;
            data_d.imm          = id_imm;
            data_d.rd           = inst_rd(id_inst);
            data_d.rs1          = inst_rs1(id_inst);
            data_d.rs2          = inst_rs2(id_inst);
            valid_d             = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign ex_mem_read     = ctrl_q.mem_read;
    assign ex_mem_to_reg   = ctrl_q.mem_to_reg;
    assign ex_mem_write    = ctrl_q.mem_write;
    assign ex_alu_src      = ctrl_q.alu_src;
    assign ex_write_enable = ctrl_q.write_enable;
    assign ex_pc_to_reg    = ctrl_q.pc_to_reg;
    assign ex_alu_op       = ctrl_q.alu_op;
    assign ex_is_ecall     = ctrl_q.is_ecall;
    assign ex_pc           = data_q.pc;
    assign ex_inst         = data_q.inst;
    assign ex_rs1_data     = data_q.rs1_data;
    assign ex_rs2_data     = data_q.rs2_data;
    assign ex_imm          = data_q.imm;
    assign ex_rd           = data_q.rd;
    assign ex_rs1          = data_q.rs1;
    assign ex_rs2          = data_q.rs2;
    assign ex_valid        = valid_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: capture, bubbles, halt drain and reset abort.
module tb_id_ex_stage_reg;
    import id_ex_stage_reg_pkg::*;

    localparam int unsigned DRAIN = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  c_in = '0;
    logic        is_stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] id_pc = '0;
    logic [31:0] id_inst = '0;
    logic [31:0] id_rs1_data = '0;
    logic [31:0] id_rs2_data = '0;
    logic [31:0] id_imm = '0;
    logic        id_x17_is_ten = 1'b0;

    logic        ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src;
    logic        ex_write_enable, ex_pc_to_reg, ex_alu_op, ex_is_ecall;
    logic [31:0] ex_pc, ex_inst, ex_rs1_data, ex_rs2_data, ex_imm;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic        ex_valid, is_halted;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        valid;
        logic        halted;
    } out_t;

    out_t sb_q[$];
    int   n_tests = 0;
    int   n_failed = 0;

    localparam logic [31:0] AddiX5 = 32'h0070_0293;
    localparam logic [31:0] LwX6   = 32'h0002_a303;
    // ctrl order: mem_read, mem_to_reg, mem_write, alu_src, write_enable, pc_to_reg, alu_op, ecall
    localparam logic [7:0]  CtlAddi  = 8'b0001_1010;
    localparam logic [7:0]  CtlLw    = 8'b1101_1000;
    localparam logic [7:0]  CtlEcall = 8'b0000_0001;

    id_ex_stage_reg #(
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_read       (c_in[7]),
        .mem_to_reg     (c_in[6]),
        .mem_write      (c_in[5]),
        .alu_src        (c_in[4]),
        .write_enable   (c_in[3]),
        .pc_to_reg      (c_in[2]),
        .alu_op         (c_in[1]),
        .is_ecall       (c_in[0]),
        .is_stall       (is_stall),
        .flush          (flush),
        .id_pc          (id_pc),
        .id_inst        (id_inst),
        .id_rs1_data    (id_rs1_data),
        .id_rs2_data    (id_rs2_data),
        .id_imm         (id_imm),
        .id_x17_is_ten  (id_x17_is_ten),
        .ex_mem_read    (ex_mem_read),
        .ex_mem_to_reg  (ex_mem_to_reg),
        .ex_mem_write   (ex_mem_write),
        .ex_alu_src     (ex_alu_src),
        .ex_write_enable(ex_write_enable),
        .ex_pc_to_reg   (ex_pc_to_reg),
        .ex_alu_op      (ex_alu_op),
        .ex_is_ecall    (ex_is_ecall),
        .ex_pc          (ex_pc),
        .ex_inst        (ex_inst),
        .ex_rs1_data    (ex_rs1_data),
        .ex_rs2_data    (ex_rs2_data),
        .ex_imm         (ex_imm),
        .ex_rd          (ex_rd),
        .ex_rs1         (ex_rs1),
        .ex_rs2         (ex_rs2),
        .ex_valid       (ex_valid),
        .is_halted      (is_halted)
    );

    always #5 clk = ~clk;

    function automatic out_t observed();
        out_t o;
        o.ctrl   = {ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src,
                    ex_write_enable, ex_pc_to_reg, ex_alu_op, ex_is_ecall};
        o.pc     = ex_pc;
        o.inst   = ex_inst;
        o.rs1d   = ex_rs1_data;
        o.rs2d   = ex_rs2_data;
        o.imm    = ex_imm;
        o.rd     = ex_rd;
        o.rs1    = ex_rs1;
        o.rs2    = ex_rs2;
        o.valid  = ex_valid;
        o.halted = is_halted;
        return o;
    endfunction

    // Expected EX contents if the current ID inputs are captured.
    function automatic out_t captured(input logic halted);
        out_t o;
        o.ctrl   = c_in;
        o.pc     = id_pc;
        o.inst   = id_inst;
        o.rs1d   = id_rs1_data;
        o.rs2d   = id_rs2_data;
        o.imm    = id_imm;
        o.rd     = id_inst[11:7];
        o.rs1    = id_inst[19:15];
        o.rs2    = id_inst[24:20];
        o.valid  = 1'b1;
        o.halted = halted;
        return o;
    endfunction

    function automatic out_t bubble(input logic halted);
        out_t o;
        o        = '0;
        o.halted = halted;
        return o;
    endfunction

    task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [7:0] ctl,
                         input logic x17, input logic stall, input logic fl);
        id_inst       = inst;
        id_pc         = pc;
        c_in          = ctl;
        id_x17_is_ten = x17;
        is_stall      = stall;
        flush         = fl;
        id_rs1_data   = $urandom;
        id_rs2_data   = $urandom;
        id_imm        = $urandom;
    endtask

    task automatic tick(input out_t e);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic pop(output out_t e, output out_t g);
        e = sb_q.pop_front();
        g = observed();
    endtask

    task automatic test_reset();
        out_t e, g;
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive($urandom, $urandom, 8'hff, 1'b1, 1'b0, 1'b0);
            tick(bubble(1'b0));
            pop(e, g);
            n_tests++;
            if (g !== e) begin
                n_failed++;
                $display("FAIL reset[%0d] got=%h exp=%h", i, g, e);
            end
        end
        reset = 1'b1;
    endtask

    task automatic test_capture();
        out_t e, g;
        drive(AddiX5, 32'h10, CtlAddi, 1'b0, 1'b0, 1'b0);
        tick(captured(1'b0));
        pop(e, g);
        n_tests++;
        if (g !== e) begin
            n_failed++;
            $display("FAIL capture_addi got=%h exp=%h", g, e);
        end
        n_tests++;
        if (ex_rd !== 5'd5 || ex_alu_src !== 1'b1 || ex_write_enable !== 1'b1 ||
            ex_pc !== 32'h10 || ex_valid !== 1'b1) begin
            n_failed++;
            $display("FAIL capture_addi_fields got rd=%0d alu_src=%b we=%b pc=%h valid=%b exp 5 1 1 10 1",
                     ex_rd, ex_alu_src, ex_write_enable, ex_pc, ex_valid);
        end
    endtask

    task automatic test_stall();
        out_t e, g;
        drive(LwX6, 32'h14, CtlLw, 1'b0, 1'b1, 1'b0);
        tick(bubble(1'b0));
        pop(e, g);
        n_tests++;
        if (g !== e) begin
            n_failed++;
            $display("FAIL stall_bubble got=%h exp=%h", g, e);
        end
        is_stall = 1'b0;
        tick(captured(1'b0));
        pop(e, g);
        n_tests++;
        if (g !== e || ex_mem_read !== 1'b1 || ex_rd !== 5'd6) begin
            n_failed++;
            $display("FAIL stall_release got=%h exp=%h", g, e);
        end
    endtask

    task automatic test_flush_stall_ecall();
        out_t e, g;
        drive(EcallInst, 32'h18, CtlEcall, 1'b1, 1'b1, 1'b1);
        tick(bubble(1'b0));
        pop(e, g);
        n_tests++;
        if (g !== e || ex_is_ecall !== 1'b0) begin
            n_failed++;
            $display("FAIL flush_stall_ecall got=%h exp=%h", g, e);
        end
        drive(EcallInst, 32'h1c, CtlEcall, 1'b1, 1'b0, 1'b1);
        tick(bubble(1'b0));
        pop(e, g);
        n_tests++;
        if (g !== e) begin
            n_failed++;
            $display("FAIL flush_ecall got=%h exp=%h", g, e);
        end
        drive(EcallInst, 32'h20, CtlEcall, 1'b1, 1'b1, 1'b0);
        tick(bubble(1'b0));
        pop(e, g);
        n_tests++;
        if (g !== e) begin
            n_failed++;
            $display("FAIL stall_ecall got=%h exp=%h", g, e);
        end
        // A killed halt ecall must leave the pipe running.
        for (int i = 0; i < DRAIN + 2; i++) begin
            drive(AddiX5 + (i << 7), 32'h24 + 4 * i, CtlAddi, 1'b1, 1'b0, 1'b0);
            tick(captured(1'b0));
            pop(e, g);
            n_tests++;
            if (g !== e) begin
                n_failed++;
                $display("FAIL after_killed_ecall[%0d] got=%h exp=%h", i, g, e);
            end
        end
    endtask

    task automatic test_nonhalt_ecall();
        out_t e, g;
        drive(EcallInst, 32'h40, CtlEcall, 1'b0, 1'b0, 1'b0);
        tick(captured(1'b0));
        pop(e, g);
        n_tests++;
        if (g !== e || ex_is_ecall !== 1'b1) begin
            n_failed++;
            $display("FAIL nonhalt_ecall got=%h exp=%h", g, e);
        end
        for (int i = 0; i < DRAIN + 2; i++) begin
            drive(LwX6, 32'h44 + 4 * i, CtlLw, 1'b0, 1'b0, 1'b0);
            tick(captured(1'b0));
            pop(e, g);
            n_tests++;
            if (g !== e) begin
                n_failed++;
                $display("FAIL nonhalt_follow[%0d] got=%h exp=%h", i, g, e);
            end
        end
    endtask

    task automatic test_halt();
        out_t e, g;
        drive(EcallInst, 32'h80, CtlEcall, 1'b1, 1'b0, 1'b0);
        tick(captured(1'b0));
        pop(e, g);
        n_tests++;
        if (g !== e || ex_is_ecall !== 1'b1) begin
            n_failed++;
            $display("FAIL halt_capture got=%h exp=%h", g, e);
        end
        for (int k = 1; k <= DRAIN + 3; k++) begin
            drive($urandom, $urandom, 8'($urandom), 1'b1, 1'($urandom), 1'($urandom));
            tick(bubble(k >= DRAIN));
            pop(e, g);
            n_tests++;
            if (g !== e) begin
                n_failed++;
                $display("FAIL halt_drain[%0d] got=%h exp=%h", k, g, e);
            end
        end
        reset = 1'b0;
        tick(bubble(1'b0));
        pop(e, g);
        n_tests++;
        if (g !== e) begin
            n_failed++;
            $display("FAIL halted_reset got=%h exp=%h", g, e);
        end
        reset = 1'b1;
    endtask

    task automatic test_reset_mid_drain();
        out_t e, g;
        drive(EcallInst, 32'hc0, CtlEcall, 1'b1, 1'b0, 1'b0);
        tick(captured(1'b0));
        pop(e, g);
        n_tests++;
        if (g !== e) begin
            n_failed++;
            $display("FAIL middrain_capture got=%h exp=%h", g, e);
        end
        drive(AddiX5, 32'hc4, CtlAddi, 1'b0, 1'b0, 1'b0);
        tick(bubble(1'b0));
        pop(e, g);
        n_tests++;
        if (g !== e) begin
            n_failed++;
            $display("FAIL middrain_bubble got=%h exp=%h", g, e);
        end
        reset = 1'b0;
        tick(bubble(1'b0));
        pop(e, g);
        n_tests++;
        if (g !== e || is_halted !== 1'b0) begin
            n_failed++;
            $display("FAIL middrain_reset got=%h exp=%h", g, e);
        end
        reset = 1'b1;
        for (int i = 0; i < DRAIN + 2; i++) begin
            drive(AddiX5, 32'hc8 + 4 * i, CtlAddi, 1'b0, 1'b0, 1'b0);
            tick(captured(1'b0));
            pop(e, g);
            n_tests++;
            if (g !== e) begin
                n_failed++;
                $display("FAIL middrain_resume[%0d] got=%h exp=%h", i, g, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        out_t e, g;
        logic st, fl;
        for (int i = 0; i < 16; i++) begin
            st = 1'($urandom);
            fl = 1'($urandom);
            drive($urandom, $urandom, 8'($urandom), 1'b0, st, fl);
            tick((st || fl) ? bubble(1'b0) : captured(1'b0));
            pop(e, g);
            n_tests++;
            if (g !== e) begin
                n_failed++;
                $display("FAIL back_to_back[%0d] st=%b fl=%b got=%h exp=%h", i, st, fl, g, e);
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_capture();
        test_stall();
        test_flush_stall_ecall();
        test_nonhalt_ecall();
        test_back_to_back();
        test_halt();
        test_reset_mid_drain();
        test_capture();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
